// File: rtl/grant_pkg.sv
// ============================================================================
// Module      : grant_pkg
// Description : Shared state encoding, default index width and width helpers
//               for the grant decoder slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package grant_pkg;

    localparam int DEFAULT_N_SEL = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    function automatic int onehot_width(input int n_sel);
        return 1 << n_sel;
    endfunction

    // Floor the range at 1 so the counter never collapses to zero width.
    function automatic int cnt_width(input int max_hold, input int gap_cycles);
        int m;
        m = (max_hold > gap_cycles) ? max_hold : gap_cycles;
        if (m < 1) m = 1;
        return $clog2(m + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/grant_decoder_if.sv
// ============================================================================
// Module      : grant_decoder_if
// Description : Encoded-request in, one-hot grant out bundle for grant_decoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface grant_decoder_if #(
    parameter int N_SEL = grant_pkg::DEFAULT_N_SEL
);
    logic [N_SEL-1:0]        code;
    logic                    code_valid;
    logic                    code_ready;
    logic                    done;
    logic [(1<<N_SEL)-1:0]   grant;
    logic [N_SEL-1:0]        grant_id;
    logic                    busy;
    logic                    timeout;

    modport master (
        output code, code_valid, done,
        input  code_ready, grant, grant_id, busy, timeout
    );

    modport slave (
        input  code, code_valid, done,
        output code_ready, grant, grant_id, busy, timeout
    );
endinterface

`default_nettype wire

// File: rtl/grant_decoder_hold_counter.sv
// ============================================================================
// Module      : hold_counter
// Description : Loadable up-counter with clear and terminal-count compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hold_counter #(
    parameter int WIDTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clr,
    input  wire logic             load,
    input  wire logic [WIDTH-1:0] load_val,
    input  wire logic             en,
    input  wire logic [WIDTH-1:0] tc_val,
    output logic      [WIDTH-1:0] count,
    output logic                  tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;
    assign tc    = (r_count == tc_val);

endmodule

`default_nettype wire

// File: rtl/grant_decoder.sv
// ============================================================================
// Module      : grant_decoder
// Description : Turns an encoded request index into a held one-hot grant,
//               released by done or hold timeout, followed by a guard gap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module grant_decoder
    import grant_pkg::*;
#(
    parameter int N_SEL      = DEFAULT_N_SEL,
    parameter int MAX_HOLD   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  wire logic        clk,
    input  wire logic        rst,
    grant_decoder_if.slave   bus
);

    localparam int c_grant_w = onehot_width(N_SEL);
    localparam int c_cnt_w   = cnt_width(MAX_HOLD, GAP_CYCLES);

    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam logic [c_cnt_w-1:0] c_gap_last  = c_cnt_w'(GAP_CYCLES);

    state_t                 r_state;
    state_t                 w_next;
    logic [c_grant_w-1:0]   r_grant;
    logic [N_SEL-1:0]       r_grant_id;
    logic                   r_busy;
    logic                   r_timeout;

    logic                   w_accept;
    logic                   w_expire;
    logic                   w_release;
    logic                   w_code_ready;
    logic                   w_cnt_en;
    logic [c_cnt_w-1:0]     w_tc_val;
    logic [c_cnt_w-1:0]     w_count;
    logic                   w_tc;
    logic [c_grant_w-1:0]   w_grant_dec;

    assign w_accept    = bus.code_valid && (r_state == ST_IDLE);
    assign w_expire    = (MAX_HOLD != 0) && (r_state == ST_GRANT) && w_tc && !bus.done;
    assign w_release   = (r_state == ST_GRANT) && (bus.done || w_expire);
    assign w_grant_dec = c_grant_w'(1) << bus.code;

    // Gap is loaded with 1 on release so its terminal count equals GAP_CYCLES.
    hold_counter #(
        .WIDTH (c_cnt_w)
    ) u_hold_counter (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_accept),
        .load     (w_release),
        .load_val (c_cnt_w'(1)),
        .en       (w_cnt_en),
        .tc_val   (w_tc_val),
        .count    (w_count),
        .tc       (w_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)  w_next = ST_GRANT;
            ST_GRANT: if (w_release) w_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (w_tc)      w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_code_ready = 1'b0;
        w_cnt_en     = 1'b0;
        w_tc_val     = c_hold_last;
        case (r_state)
            ST_IDLE:  w_code_ready = 1'b1;
            ST_GRANT: w_cnt_en     = 1'b1;
            ST_GAP: begin
                w_cnt_en = 1'b1;
                w_tc_val = c_gap_last;
            end
            default:  w_code_ready = 1'b0;
        endcase
    end

    // Code is only looked at on acceptance, so an unknown code while
    // code_valid is low can never land in the grant register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            r_timeout <= w_expire;
            r_busy    <= (w_next != ST_IDLE);
            if (w_accept) begin
                r_grant    <= w_grant_dec;
                r_grant_id <= bus.code;
            end else if (w_next != ST_GRANT) begin
                r_grant <= '0;
            end
        end
    end

    assign bus.code_ready = w_code_ready;
    assign bus.grant      = r_grant;
    assign bus.grant_id   = r_grant_id;
    assign bus.busy       = r_busy;
    assign bus.timeout    = r_timeout;

endmodule

`default_nettype wire
